// File: rtl/sensor_readout.sv
// Row readout: captures a row on NEW_ROW and streams it column by column via a show-ahead FIFO, first word valid 1 cycle after the strobe.
// OUT_READY low fills the FIFO and stalls the row; NEW_ROW mid-row is dropped (ROW_DROP). READOUT_GRAY_DECODE_EN enables Gray-to-binary decode.
module sensor_readout #(
  parameter int PIXEL_BITS   = 8,
  parameter int ARRAY_WIDTH  = 2,
  parameter int ARRAY_HEIGHT = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              NEW_ROW,
  input  logic                              FRAME_FINISHED,
  input  logic [ARRAY_WIDTH*PIXEL_BITS-1:0] ROW_DATA,
  output logic [PIXEL_BITS-1:0]             OUT_DATA,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic                              OUT_FIRST,
  output logic                              OUT_LAST,
  output logic                              OUT_EOL,
  output logic                              ROW_DROP
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = AW + 1;
  localparam int CW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam int RW = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
  localparam int EW = PIXEL_BITS + 3;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                          state_q;
  logic [ARRAY_WIDTH*PIXEL_BITS-1:0] row_buf_q;
  logic [RW-1:0]                   tag_q;
  logic [RW-1:0]                   row_idx_q;
  logic [RW-1:0]                   row_idx_d;
  logic [RW-1:0]                   row_inc;
  logic [CW-1:0]                   col_q;
  logic                            drop_q;
  logic [AW-1:0]                   wr_ptr_q;
  logic [AW-1:0]                   rd_ptr_q;
  logic [NW-1:0]                   count_q;
  logic [NW-1:0]                   count_d;
  logic [EW-1:0]                   mem_q [FIFO_DEPTH];

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  col_end;
  logic                  final_push;
  logic [PIXEL_BITS-1:0] pix_raw;
  logic [PIXEL_BITS-1:0] pix;
  logic                  first_f;
  logic                  eol_f;
  logic                  last_f;
  logic [EW-1:0]         push_dat;
  logic [EW-1:0]         head;

  // Full test uses the registered count, so a same-edge pop never frees a slot.
  assign full       = (count_q == NW'(FIFO_DEPTH));
  assign push       = (state_q == ST_SHIFT) && !full;
  assign pop        = OUT_VALID && OUT_READY;
  assign col_end    = (col_q == CW'(ARRAY_WIDTH - 1));
  assign final_push = push && col_end;

  assign pix_raw = row_buf_q[int'(col_q)*PIXEL_BITS +: PIXEL_BITS];

`ifdef READOUT_GRAY_DECODE_EN
  function automatic logic [PIXEL_BITS-1:0] gray2bin(input logic [PIXEL_BITS-1:0] g);
    logic [PIXEL_BITS-1:0] b;
    b[PIXEL_BITS-1] = g[PIXEL_BITS-1];
    for (int i = PIXEL_BITS - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  assign pix = gray2bin(pix_raw);
`else
  assign pix = pix_raw;
`endif

  assign first_f  = (tag_q == '0) && (col_q == '0);
  assign eol_f    = col_end;
  assign last_f   = col_end && (tag_q == RW'(ARRAY_HEIGHT - 1));
  assign push_dat = {first_f, last_f, eol_f, pix};

  assign row_inc   = (row_idx_q == RW'(ARRAY_HEIGHT - 1)) ? '0 : row_idx_q + RW'(1);
  assign row_idx_d = FRAME_FINISHED ? '0 : (final_push ? row_inc : row_idx_q);

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + NW'(1);
    else if (!push && pop) count_d = count_q - NW'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      row_buf_q <= '0;
      tag_q     <= '0;
      row_idx_q <= '0;
      col_q     <= '0;
      drop_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      count_q   <= count_d;
      row_idx_q <= row_idx_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case (state_q)
        ST_IDLE: begin
          if (NEW_ROW) begin
            row_buf_q <= ROW_DATA;
            tag_q     <= row_idx_q;
            col_q     <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (final_push) begin
            col_q <= '0;
            // Back-to-back row takes the index the finishing row hands over.
            if (NEW_ROW) begin
              row_buf_q <= ROW_DATA;
              tag_q     <= row_idx_d;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            if (push)    col_q  <= col_q + CW'(1);
            if (NEW_ROW) drop_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head      = mem_q[rd_ptr_q];
  assign OUT_VALID = (count_q != '0);
  assign OUT_DATA  = OUT_VALID ? head[PIXEL_BITS-1:0] : '0;
  assign OUT_EOL   = OUT_VALID && head[PIXEL_BITS];
  assign OUT_LAST  = OUT_VALID && head[PIXEL_BITS+1];
  assign OUT_FIRST = OUT_VALID && head[PIXEL_BITS+2];
  assign ROW_DROP  = drop_q;

endmodule

// File: tb/tb_sensor_readout.sv
// Bench for sensor_readout: directed vector table, hand-written corner sequences, and randomized traffic against a queue-based model.
module tb_sensor_readout;
  localparam int P = 8;
  localparam int W = 2;
  localparam int H = 2;
  localparam int D = 4;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           NEW_ROW;
  logic           FRAME_FINISHED;
  logic [W*P-1:0] ROW_DATA;
  logic [P-1:0]   OUT_DATA;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic           OUT_FIRST;
  logic           OUT_LAST;
  logic           OUT_EOL;
  logic           ROW_DROP;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  sensor_readout #(
    .PIXEL_BITS(P), .ARRAY_WIDTH(W), .ARRAY_HEIGHT(H), .FIFO_DEPTH(D)
  ) dut (
    .CLK(CLK), .RESET(RESET), .NEW_ROW(NEW_ROW), .FRAME_FINISHED(FRAME_FINISHED),
    .ROW_DATA(ROW_DATA), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_FIRST(OUT_FIRST), .OUT_LAST(OUT_LAST), .OUT_EOL(OUT_EOL), .ROW_DROP(ROW_DROP)
  );

  typedef struct {
    logic [P-1:0] dat;
    logic first, last, eol;
  } ent_t;

  typedef struct {
    logic nr, ff, rdy;
    logic [W*P-1:0] row;
    logic vld;
    logic [P-1:0] dat;
    logic first, last, eol, drop;
  } vec_t;

  // Expected pixel value after the optional Gray decode (prefix XOR of the code).
  function automatic logic [P-1:0] xp(input logic [P-1:0] g);
    logic [P-1:0] b;
    b = g;
`ifdef READOUT_GRAY_DECODE_EN
    for (int s = 1; s < P; s++) b = b ^ (g >> s);
`endif
    return b;
  endfunction

  function automatic logic [31:0] pk(input logic v, input logic [P-1:0] d,
                                     input logic f, input logic l, input logic e, input logic dr);
    return {19'd0, v, d, f, l, e, dr};
  endfunction

  function automatic logic [31:0] obs();
    return pk(OUT_VALID, OUT_DATA, OUT_FIRST, OUT_LAST, OUT_EOL, ROW_DROP);
  endfunction

  function automatic vec_t mkv(input logic nr, input logic ff, input logic [W*P-1:0] row,
                               input logic vld, input logic [P-1:0] dat,
                               input logic f, input logic l, input logic e);
    vec_t v;
    v.nr = nr; v.ff = ff; v.rdy = 1'b1; v.row = row;
    v.vld = vld; v.dat = dat; v.first = f; v.last = l; v.eol = e; v.drop = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic nr, input logic ff, input logic [W*P-1:0] row, input logic rdy);
    NEW_ROW        = nr;
    FRAME_FINISHED = ff;
    ROW_DATA       = row;
    OUT_READY      = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // Reference model: output FIFO and pending row columns as queues.
  ent_t mq[$];
  ent_t pq[$];
  int   midx;
  bit   mdrop;

  task automatic load(input logic [W*P-1:0] row, input int tag);
    for (int c = 0; c < W; c++) begin
      ent_t e;
      e.dat   = xp(row[c*P +: P]);
      e.eol   = (c == W - 1);
      e.first = (tag == 0) && (c == 0);
      e.last  = e.eol && (tag == H - 1);
      pq.push_back(e);
    end
  endtask

  task automatic model_edge(input bit nr, input bit ff, input bit rdy, input logic [W*P-1:0] row);
    int sz;
    bit idle, do_pop, do_push, fin;
    int nxt;
    sz      = mq.size();
    idle    = (pq.size() == 0);
    do_pop  = (sz > 0) && rdy;
    do_push = !idle && (sz < D);
    fin     = do_push && (pq.size() == 1);
    nxt     = midx;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(pq.pop_front());
    if (fin) nxt = (midx + 1) % H;
    if (ff) nxt = 0;
    if (nr) begin
      if (idle) load(row, midx);
      else if (fin) load(row, nxt);
      else mdrop = 1'b1;
    end
    midx = nxt;
  endtask

  vec_t tbl[10];
  logic [P-1:0] got[$];

  initial begin
    RESET = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    tick();
    check("reset_held", obs(), 32'd0);
    RESET = 1'b0;
    tick();
    check("reset_state", obs(), 32'd0);

    // Single row, then two back-to-back rows after a frame realign.
    tbl[0] = mkv(1'b1, 1'b0, 16'hB2A1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[1] = mkv(1'b0, 1'b0, 16'h0000, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
    tbl[2] = mkv(1'b0, 1'b0, 16'h0000, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
    tbl[3] = mkv(1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[4] = mkv(1'b1, 1'b0, 16'h0201, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[5] = mkv(1'b0, 1'b0, 16'h0000, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    tbl[6] = mkv(1'b1, 1'b0, 16'h0403, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    tbl[7] = mkv(1'b0, 1'b0, 16'h0000, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    tbl[8] = mkv(1'b0, 1'b0, 16'h0000, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1);
    tbl[9] = mkv(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].nr, tbl[i].ff, tbl[i].row, tbl[i].rdy);
      tick();
      if (tbl[i].vld)
        check($sformatf("vec%0d", i), obs(),
              pk(1'b1, xp(tbl[i].dat), tbl[i].first, tbl[i].last, tbl[i].eol, tbl[i].drop));
      else
        check($sformatf("vec%0d_idle", i), {30'd0, OUT_VALID, ROW_DROP}, {30'd0, 1'b0, tbl[i].drop});
    end

    // Backpressure: fill FIFO, stall third row, drop a fourth, then drain.
    do_reset();
    drive(1'b1, 1'b0, 16'h0201, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0); tick();
    drive(1'b1, 1'b0, 16'h0403, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0); tick();
    drive(1'b1, 1'b0, 16'h0605, 1'b0); tick();
    check("full_no_drop", obs(), pk(1'b1, xp(8'h01), 1'b1, 1'b0, 1'b0, 1'b0));
    drive(1'b1, 1'b0, 16'h0807, 1'b0); tick();
    check("drop_set", obs(), pk(1'b1, xp(8'h01), 1'b1, 1'b0, 1'b0, 1'b1));
    drive(1'b0, 1'b0, 16'h0000, 1'b0); tick(); tick();
    check("stall_hold", obs(), pk(1'b1, xp(8'h01), 1'b1, 1'b0, 1'b0, 1'b1));
    OUT_READY = 1'b1;
    got.delete();
    for (int c = 0; c < 30; c++) begin
      if (OUT_VALID) got.push_back(OUT_DATA);
      tick();
    end
    check("drain_count", got.size(), 32'd6);
    for (int i = 0; i < got.size() && i < 6; i++)
      check($sformatf("drain%0d", i), {24'd0, got[i]}, {24'd0, xp(P'(i + 1))});
    check("drop_sticky", {31'd0, ROW_DROP}, 32'd1);

    // Asynchronous reset with data in flight.
    drive(1'b1, 1'b0, 16'h0A09, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0); tick(); tick();
    check("pre_reset_vld", {31'd0, OUT_VALID}, 32'd1);
    #2 RESET = 1'b1;
    #1 check("async_reset", obs(), 32'd0);
    tick();
    RESET = 1'b0;
    tick();
    check("post_reset_idle", obs(), 32'd0);

    // FRAME_FINISHED realign, and override of a same-edge increment.
    drive(1'b1, 1'b0, 16'h0201, 1'b1); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1); tick(); tick();
    drive(1'b0, 1'b1, 16'h0000, 1'b1); tick();
    drive(1'b1, 1'b0, 16'h0403, 1'b1); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1); tick();
    check("ff_first", obs(), pk(1'b1, xp(8'h03), 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    check("ff_not_last", obs(), pk(1'b1, xp(8'h04), 1'b0, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b1, 16'h0000, 1'b1); tick();
    drive(1'b1, 1'b0, 16'h0605, 1'b1); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1); tick();
    check("ff_row0", obs(), pk(1'b1, xp(8'h05), 1'b1, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 1'b1, 16'h0000, 1'b1); tick();
    drive(1'b1, 1'b0, 16'h0807, 1'b1); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1); tick();
    check("ff_override", obs(), pk(1'b1, xp(8'h07), 1'b1, 1'b0, 1'b0, 1'b0));
    tick();

    // Gray decode path on a tag-1 row.
    drive(1'b1, 1'b0, 16'h80C0, 1'b1); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1); tick();
`ifdef READOUT_GRAY_DECODE_EN
    check("gray_c0", {24'd0, OUT_DATA}, 32'h80);
    tick();
    check("gray_c1", {24'd0, OUT_DATA}, 32'hFF);
`else
    check("gray_c0", {24'd0, OUT_DATA}, 32'hC0);
    tick();
    check("gray_c1", {24'd0, OUT_DATA}, 32'h80);
`endif
    tick();

    // Randomized traffic against the queue model, in segments with fresh resets.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      mq.delete(); pq.delete(); midx = 0; mdrop = 1'b0;
      for (int cyc = 0; cyc < 750; cyc++) begin
        bit nr, ff, rdy;
        logic [W*P-1:0] row;
        nr  = ($urandom_range(0, 2) == 0);
        ff  = !nr && ($urandom_range(0, 15) == 0);
        rdy = ((cyc / 100) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        row = W*P'($urandom);
        drive(nr, ff, row, rdy);
        model_edge(nr, ff, rdy, row);
        tick();
        if (mq.size() > 0)
          check("rand", obs(), pk(1'b1, mq[0].dat, mq[0].first, mq[0].last, mq[0].eol, mdrop));
        else
          check("rand_idle", {30'd0, OUT_VALID, ROW_DROP}, {30'd0, 1'b0, mdrop});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_readout.md
Name: sensor_readout

Overview:
Row readout stage directly downstream of the sensor state sequencer. On each NEW_ROW strobe it captures one row of pixel ADC words from the array bus and serializes them column by column into a small FIFO. The FIFO drives a valid/ready pixel stream with frame and line markers. FRAME_FINISHED from the sequencer realigns the row index for the next frame.

Parameters:
PIXEL_BITS, 8, width of one pixel word
ARRAY_WIDTH, 2, pixels per row (columns)
ARRAY_HEIGHT, 2, rows per frame
FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  reset, asynchronous, active-high
NEW_ROW  in  1  row strobe from sequencer; ROW_DATA is valid on the same edge
FRAME_FINISHED  in  1  end-of-frame strobe from sequencer
ROW_DATA  in  ARRAY_WIDTH*PIXEL_BITS  row bus; column c at [c*PIXEL_BITS +: PIXEL_BITS]
OUT_DATA  out  PIXEL_BITS  pixel word at FIFO head
OUT_VALID  out  1  FIFO not empty
OUT_READY  in  1  consumer accepts word
OUT_FIRST  out  1  head word is column 0 of row 0
OUT_LAST  out  1  head word is the last column of row ARRAY_HEIGHT-1
OUT_EOL  out  1  head word is the last column of any row
ROW_DROP  out  1  sticky flag: a row was discarded; cleared only by RESET

Behaviour:
- Reset:
  - FIFO empty.
  - OUT_VALID, OUT_DATA, OUT_FIRST, OUT_LAST, OUT_EOL, ROW_DROP = 0.
  - Row index = 0, column index = 0, FSM = IDLE.
- FSM IDLE:
  - NEW_ROW=1 at an edge: latch ROW_DATA into the row buffer, latch the current row index as the row tag, column = 0, go to SHIFT.
- FSM SHIFT, each edge:
  - If the FIFO is not full (registered count < FIFO_DEPTH): push {pixel[column], flags}, then column++.
  - If the FIFO is full: stall; no push and column holds.
  - Push with column == ARRAY_WIDTH-1: row index = (row index+1) mod ARRAY_HEIGHT, go to IDLE.
- Flags written with each entry:
  - FIRST = (tag==0 && col==0).
  - EOL = (col==ARRAY_WIDTH-1).
  - LAST = EOL && tag==ARRAY_HEIGHT-1.
- NEW_ROW during SHIFT:
  - If the final push of the current row happens on that same edge, the new row is captured and the FSM stays in SHIFT. This gives back-to-back rows with no lost cycle.
  - Otherwise the new row is discarded, ROW_DROP is set to 1, and the in-flight row continues unaffected.
- FRAME_FINISHED=1 at an edge: row index forced to 0. This overrides any same-edge increment. An in-flight row keeps its latched tag.
- Latency: NEW_ROW sampled at edge k → column 0 written at edge k+1 → OUT_VALID=1 after edge k+1 if the FIFO was empty. With OUT_READY held at 1, one pixel per cycle; a row takes ARRAY_WIDTH cycles.
- Output handshake:
  - Transfer occurs when OUT_VALID && OUT_READY at an edge.
  - OUT_DATA and the flags are show-ahead from the FIFO head and stay stable while OUT_VALID && !OUT_READY.
  - OUT_VALID never deasserts without a transfer.
- FIFO:
  - Simultaneous push and pop is allowed at any count below full; count is unchanged.
  - At full, push is blocked even if a pop occurs on the same edge, because the full test uses the registered count.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Asynchronous RESET mid-operation clears all state immediately. Partial rows are lost; no ROW_DROP is recorded.

Optional Feature:
- Macro READOUT_GRAY_DECODE_EN.
- Defined: each pixel word is treated as Gray code, matching the digital ramp encoding, and converted to binary (b[MSB]=g[MSB], b[i]=b[i+1]^g[i]) before the FIFO push. Latency is unchanged.
- Undefined: pixel words pass through unmodified.

Test Plan:
- RESET, then NEW_ROW with ROW_DATA=16'hB2A1, OUT_READY=1 → outputs 8'hA1 (FIRST=1, EOL=0) then 8'hB2 (EOL=1, LAST=0) on consecutive cycles; OUT_VALID first seen 1 cycle after the strobe.
- Two rows 16'h0201 and 16'h0403 strobed exactly 2 cycles apart → 01,02,03,04 contiguous; LAST=1 on 04 only; ROW_DROP=0.
- OUT_READY=0 and three rows strobed 2 cycles apart → FIFO holds 4 words; third row stalls at column 0; OUT_DATA=01 held stable; ROW_DROP=0.
- NEW_ROW repeated 1 cycle after the previous NEW_ROW, while OUT_READY=0 and FIFO full → second row dropped, ROW_DROP=1 and stays 1 until RESET.
- FRAME_FINISHED pulsed after row 0 only → next row tagged 0: FIRST=1 on its column 0, LAST=0.
- With READOUT_GRAY_DECODE_EN defined, ROW_DATA=16'h80C0 → outputs 8'h80, then 8'hFF.
